// File: rtl/msg_tx_arb.sv
// msg_tx_arb: round-robin arbiter sharing one line coder between message controllers.
// Define MSG_TX_ARB_TIMEOUT_EN to build the grant watchdog and err_timeout pulse.
module msg_tx_arb #(
  parameter int REQ_NUM        = 4,
  parameter int GAP_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic [REQ_NUM-1:0]   req,
  output logic [REQ_NUM-1:0]   tx_rdy_o,
  input  logic [REQ_NUM-1:0]   tx_en,
  input  logic [8*REQ_NUM-1:0] q,
  input  logic [REQ_NUM-1:0]   q_rdy,
  input  logic [REQ_NUM-1:0]   msg_end,
  input  logic                 cd_busy,
  output logic [REQ_NUM-1:0]   cd_busy_o,
  output logic [7:0]           cd_q,
  output logic                 cd_q_rdy,
  output logic [REQ_NUM-1:0]   gnt,
  output logic                 arb_busy,
  output logic                 err_timeout
);
  localparam int LW = $clog2(REQ_NUM);
  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;
  state_t             state_q, state_d;
  logic [REQ_NUM-1:0] gnt_q, gnt_d;
  logic [LW-1:0]      last_q, last_d, pick, idx;
  logic [3:0]         gap_q, gap_d;
  logic               err_q, err_d, found, rel_end, rel_wd, rel_to;

  assign rel_end = |(msg_end & gnt_q);
  assign rel_wd  = |(gnt_q & ~req & ~tx_en);

`ifdef MSG_TX_ARB_TIMEOUT_EN
  logic [10:0] wd_q;
  assign rel_to = (wd_q == 11'(TIMEOUT_CYCLES));
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) wd_q <= '0;
    else wd_q <= (state_q != GRANT || cd_q_rdy) ? '0 : wd_q + 11'd1;
`else
  assign rel_to = 1'b0;
`endif

  // scan upward from last+1 with wrap; first requester found wins
  always_comb begin
    pick  = last_q;
    found = 1'b0;
    idx   = last_q;
    for (int k = 0; k < REQ_NUM; k++) begin
      idx = (idx == LW'(REQ_NUM-1)) ? '0 : idx + 1'b1;
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    gap_d   = gap_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE: if (found) begin
        state_d = GRANT;
        gnt_d   = {{(REQ_NUM-1){1'b0}}, 1'b1} << pick;
        last_d  = pick;
      end
      GRANT: if (rel_end || rel_wd || rel_to) begin
        state_d = GAP;
        gnt_d   = '0;
        gap_d   = 4'(GAP_CYCLES);
        err_d   = rel_to && !rel_end && !rel_wd;
      end
      GAP: begin
        state_d = (gap_q == '0) ? IDLE : GAP;
        gap_d   = (gap_q == '0) ? '0 : gap_q - 4'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      last_q  <= LW'(REQ_NUM-1);
      gap_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      gap_q   <= gap_d;
      err_q   <= err_d;
    end

  always_comb begin
    cd_q = '0;
    for (int i = 0; i < REQ_NUM; i++) cd_q |= q[8*i +: 8] & {8{gnt_q[i]}};
  end

  assign cd_q_rdy    = |(q_rdy & gnt_q);
  assign tx_rdy_o    = req & gnt_q;
  assign cd_busy_o   = {REQ_NUM{cd_busy}} & gnt_q;
  assign gnt         = gnt_q;
  assign arb_busy    = (state_q != IDLE);
  assign err_timeout = err_q;
endmodule

// File: tb/tb_msg_tx_arb.sv
// tb_msg_tx_arb: random and directed stimulus against a grant-level reference model.
module tb_msg_tx_arb;
  localparam int N = 4, LW = 2, G = 2, T = 16, QW = 8 * N;
`ifdef MSG_TX_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  logic clk = 1'b0, n_rst = 1'b0, cd_busy = 1'b0;
  logic [N-1:0] req = '0, tx_en = '0, q_rdy = '0, msg_end = '0;
  logic [QW-1:0] q = '0;
  logic [N-1:0] tx_rdy_o, cd_busy_o, gnt;
  logic [7:0] cd_q;
  logic cd_q_rdy, arb_busy, err_timeout;
  int errs = 0, checks = 0;
  int m_g = -1, m_last = N - 1, m_cool = 0, m_wd = 0;
  bit m_err = 1'b0;

  always #5 clk = ~clk;

  msg_tx_arb #(.REQ_NUM(N), .GAP_CYCLES(G), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .n_rst(n_rst), .req(req), .tx_rdy_o(tx_rdy_o), .tx_en(tx_en), .q(q),
    .q_rdy(q_rdy), .msg_end(msg_end), .cd_busy(cd_busy), .cd_busy_o(cd_busy_o),
    .cd_q(cd_q), .cd_q_rdy(cd_q_rdy), .gnt(gnt), .arb_busy(arb_busy), .err_timeout(err_timeout));

  function automatic bit bitof(input logic [N-1:0] v, input int i);
    return v[i[LW-1:0]];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference: one owner at a time, a cool-down of G+1 clocks after release, then rr pick
  always @(posedge clk or negedge n_rst) begin : model
    int ng, nl, nc, nw;
    bit ne;
    if (!n_rst) begin
      m_g <= -1; m_last <= N - 1; m_cool <= 0; m_wd <= 0; m_err <= 1'b0;
    end else begin
      ng = m_g; nl = m_last; nc = m_cool; nw = m_wd; ne = 1'b0;
      if (m_g >= 0) begin
        if (bitof(msg_end, m_g) || (!bitof(req, m_g) && !bitof(tx_en, m_g))) begin
          ng = -1; nc = G + 1;
        end else if (TO_EN && m_wd == T) begin
          ng = -1; nc = G + 1; ne = 1'b1;
        end else nw = bitof(q_rdy, m_g) ? 0 : m_wd + 1;
      end else if (m_cool > 0) nc = m_cool - 1;
      else
        for (int k = 1; k <= N; k++)
          if (ng < 0 && bitof(req, (m_last + k) % N)) begin
            ng = (m_last + k) % N; nl = ng; nw = 0;
          end
      m_g <= ng; m_last <= nl; m_cool <= nc; m_wd <= nw; m_err <= ne;
    end
  end

  always @(negedge clk) begin : compare
    logic [N-1:0] eg;
    eg = (m_g >= 0) ? N'(1) << m_g : '0;
    chk("gnt", gnt, eg);
    chk("tx_rdy_o", tx_rdy_o, req & eg);
    chk("cd_busy_o", cd_busy_o, cd_busy ? eg : '0);
    chk("cd_q", cd_q, (m_g >= 0) ? 8'(q >> (8 * m_g)) : 8'h00);
    chk("cd_q_rdy", cd_q_rdy, (m_g >= 0) && bitof(q_rdy, m_g));
    chk("arb_busy", arb_busy, (m_g >= 0) || (m_cool > 0));
    chk("err_timeout", err_timeout, m_err);
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    req = '0; tx_en = '0; q_rdy = '0; msg_end = '0; cd_busy = 1'b0; q = '0;
    n_rst = 1'b0;
    tick();
    tick();
    n_rst = 1'b1;
  endtask

  task automatic wait_gnt();
    int n;
    n = 0;
    while (gnt == '0 && n < 20) begin
      tick();
      n++;
    end
    chk("grant_seen", gnt != '0, 1);
  endtask

  initial begin
    int n, n_err;
    do_reset();
    chk("rst_gnt", gnt, 0);
    chk("rst_busy", arb_busy, 0);
    req = 4'b0110;
    tick();
    chk("first_gnt", gnt, 4'b0010);
    msg_end = 4'b0010;
    tick();
    msg_end = '0;
    n = 0;
    while (gnt == '0 && n < 20) begin
      n++;
      tick();
    end
    chk("gap_len", n, G + 2);
    chk("second_gnt", gnt, 4'b0100);

    do_reset();
    q = {8'hC3, 8'h5A, 8'hA5, 8'h3C};
    q_rdy = 4'hF; tx_en = 4'hF; req = 4'hF;
    for (int m = 0; m < 8; m++) begin
      wait_gnt();
      chk("rr_order", gnt, 32'(1) << (m % 4));
      if (m % 4 == 2) chk("cd_q_ctrl2", cd_q, 8'h5A);
      msg_end = gnt;
      tick();
      msg_end = '0;
    end

    do_reset();
    req = 4'b0001;
    tick();
    chk("np_gnt0", gnt, 4'b0001);
    req = 4'b1001; cd_busy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("np_hold", gnt, 4'b0001);
      chk("np_tx_rdy3", tx_rdy_o[3], 0);
      chk("np_busy", cd_busy_o, 4'b0001);
    end
    msg_end = 4'b0001;
    tick();
    msg_end = '0;
    wait_gnt();
    chk("np_next", gnt, 4'b1000);

    do_reset();
    req = 4'b0100;
    tick();
    chk("wd_gnt2", gnt, 4'b0100);
    req = '0;
    tick();
    chk("wd_rel", gnt, 0);
    chk("wd_gap", arb_busy, 1);
    chk("wd_err", err_timeout, 0);

    do_reset();
    req = 4'b0010; tx_en = 4'b0010;
    tick();
    chk("to_gnt1", gnt, 4'b0010);
    n_err = 0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (err_timeout) begin
        n_err++;
        chk("to_gnt_at_err", gnt, 0);
      end
    end
`ifdef MSG_TX_ARB_TIMEOUT_EN
    chk("to_pulses", n_err, 1);
`else
    chk("to_pulses", n_err, 0);
    chk("to_hold", gnt, 4'b0010);
`endif

    do_reset();
    q = 32'h1122_3344; req = 4'b0001; q_rdy = 4'b0001; tx_en = 4'b0001;
    tick();
    chk("mid_q_rdy", cd_q_rdy, 1);
    chk("mid_cd_q", cd_q, 8'h44);
    n_rst = 1'b0;
    #1;
    chk("mid_gnt", gnt, 0);
    chk("mid_q_rdy0", cd_q_rdy, 0);
    chk("mid_cd_q0", cd_q, 0);
    chk("mid_tx_rdy", tx_rdy_o, 0);
    chk("mid_busy", arb_busy, 0);
    tick();
    n_rst = 1'b1; req = 4'hF;
    wait_gnt();
    chk("mid_first", gnt, 4'b0001);

    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) req = req ^ N'($urandom);
      tx_en   = N'($urandom);
      q       = QW'($urandom);
      q_rdy   = ($urandom_range(0, 7) == 0) ? N'($urandom) : '0;
      msg_end = ($urandom_range(0, 15) == 0) ? N'($urandom) : '0;
      cd_busy = 1'($urandom);
      n_rst   = ($urandom_range(0, 499) != 0);
      tick();
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
